x25519_ladder_ctrl: RTL and testbench

Parametrised Montgomery-ladder controller for X25519 scalar multiplication. It walks the scalar from a configurable top bit down to bit 0, issues one ladder-step request per bit to an external step engine, and carries the projective (x,z) pair between steps. It optionally clamps the scalar, supports abort, and runs a per-step watchdog. It sits between the key-exchange front end and the per-bit ladder-step datapath, and owns all iteration state.

---
 rtl/x25519_ladder_ctrl.sv | 159 +++++++++++++++
 tb/tb_x25519_ladder_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_ladder_ctrl.sv
// Montgomery-ladder sequencer for X25519: walks the scalar from TOP_BIT down to 0,
// hands each bit and the current (x,z) pair to an external step engine, and collects the result.
module x25519_ladder_ctrl #(
  parameter int unsigned WIDTH        = 256,
  parameter int unsigned SCALAR_WIDTH = 256,
  parameter int unsigned TOP_BIT      = 254,
  parameter bit          CLAMP        = 1'b1,
  parameter int unsigned TIMEOUT      = 4095
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [SCALAR_WIDTH-1:0] scalar_i,
  input  logic [WIDTH-1:0]        u_in_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [2*WIDTH-1:0]      result_o,
  output logic [7:0]              bit_idx_o,
  output logic                    step_en_o,
  output logic                    step_b_o,
  output logic [2*WIDTH-1:0]      step_xzm_o,
  output logic [2*WIDTH-1:0]      step_xzm1_o,
  input  logic                    step_valid_i,
  input  logic [2*WIDTH-1:0]      step_xzm_res_i,
  input  logic [2*WIDTH-1:0]      step_xzm1_res_i
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned IDX_W = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state_q;
  logic [SCALAR_WIDTH-1:0] scalar_q;
  logic [PW-1:0]           xzm_q;
  logic [PW-1:0]           xzm1_q;
  logic [PW-1:0]           result_q;
  logic [7:0]              bit_idx_q;
  logic [7:0]              bit_idx_d;
  logic [WD_W-1:0]         wdog_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    step_en_q;
  logic                    step_b_q;
  logic [SCALAR_WIDTH-1:0] k_load;

  // RFC 7748 clamping applied as the scalar is captured
  generate
    if (CLAMP) begin : g_clamp
      assign k_load = {1'b0, 1'b1, scalar_i[253:3], 3'b000};
    end else begin : g_raw
      assign k_load = scalar_i;
    end
  endgenerate

  assign bit_idx_d = bit_idx_q - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      scalar_q  <= '0;
      xzm_q     <= '0;
      xzm1_q    <= '0;
      result_q  <= '0;
      bit_idx_q <= '0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      step_en_q <= 1'b0;
      step_b_q  <= 1'b0;
    end else begin
      step_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (abort_i && (state_q != IDLE)) begin
        // abort wins over a coincident step_valid and wipes key material
        state_q   <= IDLE;
        scalar_q  <= '0;
        xzm_q     <= '0;
        xzm1_q    <= '0;
        bit_idx_q <= '0;
        wdog_q    <= '0;
        busy_q    <= 1'b0;
        step_b_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i && !abort_i) begin
              scalar_q  <= k_load;
              xzm_q     <= {WIDTH'(0), WIDTH'(1)};
              xzm1_q    <= {WIDTH'(1), u_in_i};
              bit_idx_q <= 8'(TOP_BIT);
              step_b_q  <= k_load[TOP_BIT];
              busy_q    <= 1'b1;
              step_en_q <= 1'b1;
              state_q   <= ISSUE;
            end
          end
          ISSUE: begin
            wdog_q  <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (step_valid_i) begin
              xzm_q  <= step_xzm_res_i;
              xzm1_q <= step_xzm1_res_i;
              if (bit_idx_q == 8'd0) begin
                result_q <= step_xzm_res_i;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                step_b_q <= 1'b0;
                state_q  <= DONE;
              end else begin
                bit_idx_q <= bit_idx_d;
                step_b_q  <= scalar_q[IDX_W'(bit_idx_d)];
                step_en_q <= 1'b1;
                state_q   <= ISSUE;
              end
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
              result_q  <= '0;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              bit_idx_q <= '0;
              step_b_q  <= 1'b0;
              state_q   <= DONE;
            end else begin
              wdog_q <= wdog_q + WD_W'(1);
            end
          end
          DONE: begin
            scalar_q <= '0;
            xzm_q    <= '0;
            xzm1_q   <= '0;
            wdog_q   <= '0;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign result_o    = result_q;
  assign bit_idx_o   = bit_idx_q;
  assign step_en_o   = step_en_q;
  assign step_b_o    = step_b_q;
  assign step_xzm_o  = xzm_q;
  assign step_xzm1_o = xzm1_q;

endmodule

// File: tb/tb_x25519_ladder_ctrl.sv
// Bench for x25519_ladder_ctrl: a small 8-bit instance for sequencing, abort, watchdog and
// reset behaviour, and a full-width instance for scalar clamping.
module tb_x25519_ladder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start8, abort8, sv8, busy8, done8, err8, en8, b8;
  logic [7:0]  k8, u8, idx8;
  logic [15:0] res8, xzm8, xzm18, xr8, xr18;

  logic         start256, sv256, busy256, done256, err256, en256, b256;
  logic [255:0] k256, u256;
  logic [7:0]   idx256;
  logic [511:0] res256, xzm256, xzm1256, xr256, xr1256;

  x25519_ladder_ctrl #(.WIDTH(8), .SCALAR_WIDTH(8), .TOP_BIT(7), .CLAMP(1'b0), .TIMEOUT(15)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .abort_i(abort8), .scalar_i(k8), .u_in_i(u8),
    .busy_o(busy8), .done_o(done8), .err_o(err8), .result_o(res8), .bit_idx_o(idx8),
    .step_en_o(en8), .step_b_o(b8), .step_xzm_o(xzm8), .step_xzm1_o(xzm18),
    .step_valid_i(sv8), .step_xzm_res_i(xr8), .step_xzm1_res_i(xr18));

  x25519_ladder_ctrl u_dut256 (
    .clk(clk), .rst(rst), .start_i(start256), .abort_i(1'b0), .scalar_i(k256), .u_in_i(u256),
    .busy_o(busy256), .done_o(done256), .err_o(err256), .result_o(res256), .bit_idx_o(idx256),
    .step_en_o(en256), .step_b_o(b256), .step_xzm_o(xzm256), .step_xzm1_o(xzm1256),
    .step_valid_i(sv256), .step_xzm_res_i(xr256), .step_xzm1_res_i(xr1256));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mock engine controls, written only by the main sequence
  int mode8     = 0;   // 0: x+1/x1+2, 1: bit-dependent mix, 2: never answers
  int lat8      = 3;
  int abort_at8 = -1;
  int stray_req8 = 0;
  // written only by the mock
  int en_total8   = 0;
  int stray_done8 = 0;

  initial begin : mock8
    int pend;
    logic [15:0] ox, ox1;
    logic ob;
    pend = 0; ox = '0; ox1 = '0; ob = 1'b0;
    sv8 = 1'b0; abort8 = 1'b0; xr8 = '0; xr18 = '0;
    forever begin
      @(posedge clk); #1;
      sv8 = 1'b0;
      abort8 = 1'b0;
      if (rst) pend = 0;
      else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            sv8 = 1'b1;
            if (mode8 == 0) begin
              xr8 = ox + 16'd1;
              xr18 = ox1 + 16'd2;
            end else begin
              xr8 = ob ? ((ox ^ ox1) + 16'h0101) : (ox + 16'h0003);
              xr18 = ob ? (ox1 + ox) : (ox1 + 16'h0002);
            end
            if (en_total8 == abort_at8) abort8 = 1'b1;
          end
        end
        if (en8) begin
          en_total8++;
          ox = xzm8; ox1 = xzm18; ob = b8;
          if (mode8 != 2) pend = lat8;
        end
        if (stray_req8 != stray_done8) begin
          stray_done8++;
          sv8 = 1'b1;
        end
      end
    end
  end

  // full-width engine echoes its operands one cycle later
  initial begin : mock256
    logic fire;
    fire = 1'b0; sv256 = 1'b0; xr256 = '0; xr1256 = '0;
    forever begin
      @(posedge clk); #1;
      sv256 = fire && !rst;
      fire = en256 && !rst;
      if (en256) begin
        xr256 = xzm256;
        xr1256 = xzm1256;
      end
    end
  end

  // ladder iteration over the scalar bits, MSB first, with the mock's step rules
  function automatic logic [15:0] model8(input logic [7:0] k, input logic [7:0] u, input int mode);
    logic [15:0] x, x1, nx;
    x = 16'h0001;
    x1 = {8'h01, u};
    for (int i = 7; i >= 0; i--) begin
      if (mode == 0) begin
        nx = x + 16'd1;
        x1 = x1 + 16'd2;
      end else begin
        nx = k[i] ? ((x ^ x1) + 16'h0101) : (x + 16'h0003);
        x1 = k[i] ? (x1 + x) : (x1 + 16'h0002);
      end
      x = nx;
    end
    return x;
  endfunction

  task automatic run8(input logic [7:0] k, input logic [7:0] u, input int glitch_k,
                      output int n_en, output logic [7:0] bseq, output int done_k,
                      output logic [15:0] res, output logic err, output logic busy_first,
                      output logic busy_done);
    n_en = 0; bseq = '0; done_k = -1; res = '0; err = 1'b0; busy_first = 1'b0; busy_done = 1'b1;
    k8 = k; u8 = u; start8 = 1'b1;
    for (int c = 1; c <= 200 && done_k < 0; c++) begin
      @(negedge clk);
      if (c == 1) busy_first = busy8 & en8;
      if (c == 1 || c == glitch_k + 1) start8 = 1'b0;
      if (c == glitch_k) start8 = 1'b1;
      if (en8) begin
        if (n_en < 8) bseq[7 - n_en] = b8;
        n_en++;
      end
      if (done8) begin
        done_k = c; res = res8; err = err8; busy_done = busy8;
      end
    end
    start8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic run256(input logic [255:0] k, input string tag);
    logic [255:0] got, expb;
    int n, first_idx, done_k;
    logic [511:0] res;
    got = '0; n = 0; first_idx = -1; done_k = -1; res = '1;
    k256 = k; u256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start256 = 1'b1;
    for (int c = 1; c <= 1200 && done_k < 0; c++) begin
      @(negedge clk);
      if (c == 1) start256 = 1'b0;
      if (en256) begin
        if (n == 0) first_idx = int'(idx256);
        got[idx256] = b256;
        n++;
      end
      if (done256) begin
        done_k = c; res = res256;
      end
    end
    expb = k;
    expb[255] = 1'b0;
    expb[254] = 1'b1;
    expb[2:0] = 3'b000;
    check({tag, "_first_idx"}, first_idx, 254);
    check({tag, "_steps"}, n, 255);
    check({tag, "_bits"}, got, expb);
    check({tag, "_done_cycle"}, done_k, 1 + 255 * 2);
    check({tag, "_res_x"}, res[255:0], 256'd1);
    check({tag, "_res_z"}, res[511:256], 256'd0);
    @(negedge clk);
  endtask

  initial begin : main
    int n_en, done_k, nbefore;
    logic [7:0] bseq, kr, ur;
    logic [15:0] res;
    logic err, bf, bd, seen, extra;

    rst = 1'b1; start8 = 1'b0; k8 = '0; u8 = '0;
    start256 = 1'b0; k256 = '0; u256 = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy8, done8, err8, en8, b8, idx8, res8, xzm8, xzm18}, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'hA5, 8'h09, 0, n_en, bseq, done_k, res, err, bf, bd);
    check("bit_order", bseq, 8'hA5);
    check("step_count", n_en, 8);
    check("done_cycle", done_k, 33);
    check("result", res, 16'h0009);
    check("err_clear", err, 1'b0);
    check("busy_with_first_step", bf, 1'b1);
    check("busy_low_at_done", bd, 1'b0);

    mode8 = 1;
    for (int i = 0; i < 6; i++) begin
      kr = 8'($urandom); ur = 8'($urandom); lat8 = int'($urandom_range(1, 4));
      run8(kr, ur, 0, n_en, bseq, done_k, res, err, bf, bd);
      check("rnd_bits", bseq, kr);
      check("rnd_steps", n_en, 8);
      check("rnd_done_cycle", done_k, 1 + 8 * (lat8 + 1));
      check("rnd_result", res, model8(kr, ur, 1));
    end
    mode8 = 0; lat8 = 3;

    // abort on the 4th step, coinciding with step_valid
    abort_at8 = en_total8 + 4;
    k8 = 8'($urandom); u8 = 8'($urandom); start8 = 1'b1;
    seen = 1'b0; nbefore = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (en8) nbefore++;
      if (abort8) seen = 1'b1;
    end
    check("abort_seen", seen, 1'b1);
    check("abort_steps_before", nbefore, 4);
    @(negedge clk);
    check("abort_clear", {busy8, done8, en8, b8, idx8, xzm8, xzm18}, 256'd0);
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      extra = extra | en8 | done8 | busy8;
    end
    check("abort_quiet", extra, 1'b0);
    abort_at8 = -1;

    mode8 = 2;
    run8(8'($urandom), 8'($urandom), 0, n_en, bseq, done_k, res, err, bf, bd);
    check("wd_done_cycle", done_k, 17);
    check("wd_err", err, 1'b1);
    check("wd_result", res, 16'h0000);
    check("wd_steps", n_en, 1);
    mode8 = 0;

    // stray step_valid while idle
    stray_req8++;
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      extra = extra | en8 | done8 | busy8;
    end
    check("stray_valid_ignored", {extra, xzm8, xzm18}, 256'd0);

    run8(8'hA5, 8'h09, 6, n_en, bseq, done_k, res, err, bf, bd);
    check("glitch_steps", n_en, 8);
    check("glitch_done_cycle", done_k, 33);
    check("glitch_result", res, 16'h0009);
    check("glitch_bits", bseq, 8'hA5);

    // reset during the wait of step 3
    k8 = 8'hA5; u8 = 8'h09; start8 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("reset_async", {busy8, done8, err8, en8, b8, idx8, res8, xzm8, xzm18}, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run8(8'hA5, 8'h09, 0, n_en, bseq, done_k, res, err, bf, bd);
    check("post_reset_result", res, 16'h0009);
    check("post_reset_steps", n_en, 8);
    check("post_reset_done_cycle", done_k, 33);

    run256('1, "clamp_ones");
    run256({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, "clamp_rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
